// File: rtl/sb_config_controller_if.sv
// Configuration-port bundle between the fabric configuration master and the
// switch-box configuration controller.
interface sb_config_controller_if #(
    parameter int NUM_ELEM = 4,
    parameter int WORD_W   = 12
);
    logic                       cfg_start;
    logic                       cfg_abort;
    logic                       cfg_valid;
    logic                       cfg_ready;
    logic [WORD_W-1:0]          cfg_data;
    logic                       cfg_commit;
    logic                       sb_en;
    logic [NUM_ELEM*WORD_W-1:0] sb_c;
    logic                       busy;
    logic                       armed;
    logic                       done;
    logic                       err;

    modport master (
        output cfg_start, cfg_abort, cfg_valid, cfg_data, cfg_commit, sb_en,
        input  cfg_ready, sb_c, busy, armed, done, err
    );

    modport slave (
        input  cfg_start, cfg_abort, cfg_valid, cfg_data, cfg_commit, sb_en,
        output cfg_ready, sb_c, busy, armed, done, err
    );
endinterface

// File: rtl/sb_config_controller.sv
// Shadow/active configuration sequencer for a column of switch-box elements:
// words load into shadow registers, then a single commit cycle updates all gates.
module sb_config_controller #(
    parameter int NUM_ELEM = 4,
    parameter int WORD_W   = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    sb_config_controller_if.slave  cfg
);
    localparam int CNT_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ELEM - 1);

    typedef enum logic [1:0] {IDLE, LOAD, ARM, COMMIT} state_t;

    state_t                     state, state_nxt;
    logic [CNT_W-1:0]           count;
    logic [WORD_W-1:0]          shadow [NUM_ELEM];
    logic [NUM_ELEM*WORD_W-1:0] active;
    logic                       done_r, err_r;
    logic                       accept, violation;
    logic                       ready_c, busy_c, armed_c;

    // Abort wins over a same-cycle word, so an aborted word never lands in shadow.
    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        busy_c    = 1'b1;
        armed_c   = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (cfg.cfg_start) state_nxt = LOAD;
            end
            LOAD: begin
                ready_c = 1'b1;
                accept  = cfg.cfg_valid && !cfg.cfg_abort;
                if (cfg.cfg_abort)              state_nxt = IDLE;
                else if (accept && count == LAST) state_nxt = ARM;
            end
            ARM: begin
                armed_c = 1'b1;
                if (cfg.cfg_abort)       state_nxt = IDLE;
                else if (cfg.cfg_commit) state_nxt = COMMIT;
            end
            COMMIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        violation = (cfg.cfg_valid  && state != LOAD) ||
                    (cfg.cfg_commit && state != ARM)  ||
                    (cfg.cfg_start  && state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_r <= (state == COMMIT);
            err_r  <= violation;
            if (state == IDLE && cfg.cfg_start)
                count <= '0;
            else if (accept && count != LAST)
                count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ELEM; i++) shadow[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_ELEM; i++)
                if (accept && count == CNT_W'(i)) shadow[i] <= cfg.cfg_data;
        end
    end

    // Active registers change only in COMMIT, so sb_c updates together with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= '0;
        end else if (state == COMMIT) begin
            for (int i = 0; i < NUM_ELEM; i++)
                active[i*WORD_W +: WORD_W] <= shadow[i];
        end
    end

    assign cfg.cfg_ready = ready_c;
    assign cfg.busy      = busy_c;
    assign cfg.armed     = armed_c;
    assign cfg.done      = done_r;
    assign cfg.err       = err_r;
    assign cfg.sb_c      = cfg.sb_en ? active : '0;
endmodule

// File: tb/tb_sb_config_controller.sv
// Self-checking bench for sb_config_controller: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_sb_config_controller;
    localparam int NE = 4;
    localparam int W  = 12;
    localparam int CW = NE * W;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    sb_config_controller_if #(.NUM_ELEM(NE), .WORD_W(W)) bus ();
    sb_config_controller #(.NUM_ELEM(NE), .WORD_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .cfg (bus)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 loading, 2 waiting for commit, 3 applying.
    int            m_phase;
    logic [W-1:0]  m_q[$];
    logic [CW-1:0] m_act;
    logic          m_done, m_err;

    typedef struct {
        logic s, a, v; logic [W-1:0] d; logic c, e;
        logic r, b, ar, dn, er; logic [CW-1:0] sc;
    } vec_t;
    vec_t tbl[9];

    task automatic check(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_q.delete(); m_act = '0; m_done = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step();
        int p;
        p      = m_phase;
        m_err  = (bus.cfg_valid && p != 1) || (bus.cfg_commit && p != 2) || (bus.cfg_start && p != 0);
        m_done = (p == 3);
        case (p)
            0: if (bus.cfg_start) begin m_phase = 1; m_q.delete(); end
            1: if (bus.cfg_abort) m_phase = 0;
               else if (bus.cfg_valid) begin
                   m_q.push_back(bus.cfg_data);
                   if (m_q.size() == NE) m_phase = 2;
               end
            2: if (bus.cfg_abort) m_phase = 0; else if (bus.cfg_commit) m_phase = 3;
            default: begin
                for (int i = 0; i < NE; i++) m_act[i*W +: W] = m_q[i];
                m_phase = 0;
            end
        endcase
    endtask

    task automatic check_model();
        check("ready", CW'(bus.cfg_ready), CW'(m_phase == 1));
        check("busy",  CW'(bus.busy),      CW'(m_phase != 0));
        check("armed", CW'(bus.armed),     CW'(m_phase == 2));
        check("done",  CW'(bus.done),      CW'(m_done));
        check("err",   CW'(bus.err),       CW'(m_err));
        check("sb_c",  bus.sb_c,           bus.sb_en ? m_act : '0);
    endtask

    task automatic apply(input logic s, input logic a, input logic v, input logic [W-1:0] d,
                         input logic c, input logic e);
        bus.cfg_start = s; bus.cfg_abort = a; bus.cfg_valid = v;
        bus.cfg_data = d;  bus.cfg_commit = c; bus.sb_en = e;
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic idle(input logic e);
        apply(1'b0, 1'b0, 1'b0, '0, 1'b0, e);
    endtask

    task automatic load_commit(input logic [W-1:0] w0, w1, w2, w3);
        apply(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 1'b1, w0, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 1'b1, w1, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 1'b1, w2, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 1'b1, w3, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        idle(1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] words[4];
        logic [CW-1:0] hold;
        words = '{12'h001, 12'h0F0, 12'hA5A, 12'hFFF};

        // start, 4 words with valid held, one idle ARM cycle, commit, done cycle, idle
        tbl[0] = '{1,0,0,12'h000,0,1, 1,1,0,0,0, 48'h0};
        tbl[1] = '{0,0,1,12'h001,0,1, 1,1,0,0,0, 48'h0};
        tbl[2] = '{0,0,1,12'h0F0,0,1, 1,1,0,0,0, 48'h0};
        tbl[3] = '{0,0,1,12'hA5A,0,1, 1,1,0,0,0, 48'h0};
        tbl[4] = '{0,0,1,12'hFFF,0,1, 0,1,1,0,0, 48'h0};
        tbl[5] = '{0,0,0,12'h000,0,1, 0,1,1,0,0, 48'h0};
        tbl[6] = '{0,0,0,12'h000,1,1, 0,1,0,0,0, 48'h0};
        tbl[7] = '{0,0,0,12'h000,0,1, 0,0,0,1,0, 48'hFFF_A5A_0F0_001};
        tbl[8] = '{0,0,0,12'h000,0,1, 0,0,0,0,0, 48'hFFF_A5A_0F0_001};

        bus.cfg_start = 1'b0; bus.cfg_abort = 1'b0; bus.cfg_valid = 1'b0;
        bus.cfg_data = '0; bus.cfg_commit = 1'b0; bus.sb_en = 1'b1;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_sb_c",  bus.sb_c, '0);
        check("rst_ready", CW'(bus.cfg_ready), '0);
        check("rst_busy",  CW'(bus.busy), '0);
        check("rst_done",  CW'(bus.done), '0);
        check("rst_err",   CW'(bus.err), '0);
        rst = 1'b0;

        for (int k = 0; k < 9; k++) begin
            apply(tbl[k].s, tbl[k].a, tbl[k].v, tbl[k].d, tbl[k].c, tbl[k].e);
            check($sformatf("tbl%0d_ready", k), CW'(bus.cfg_ready), CW'(tbl[k].r));
            check($sformatf("tbl%0d_busy", k),  CW'(bus.busy),      CW'(tbl[k].b));
            check($sformatf("tbl%0d_armed", k), CW'(bus.armed),     CW'(tbl[k].ar));
            check($sformatf("tbl%0d_done", k),  CW'(bus.done),      CW'(tbl[k].dn));
            check($sformatf("tbl%0d_err", k),   CW'(bus.err),       CW'(tbl[k].er));
            check($sformatf("tbl%0d_sb_c", k),  bus.sb_c,           tbl[k].sc);
        end

        // valid toggling: same words captured in order, garbage on idle beats ignored
        do_reset();
        apply(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) apply(1'b0, 1'b0, 1'b1, words[k/2], 1'b0, 1'b1);
            else            apply(1'b0, 1'b0, 1'b0, W'($urandom), 1'b0, 1'b1);
            check("toggle_hold", bus.sb_c, '0);
        end
        apply(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        idle(1'b1);
        check("toggle_sb_c", bus.sb_c, 48'hFFF_A5A_0F0_001);
        check("toggle_done", CW'(bus.done), CW'(1));

        // abort after a partial reload keeps the old routing
        load_commit(12'h111, 12'h111, 12'h111, 12'h111);
        idle(1'b1);
        apply(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 1'b1, 12'h222, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 1'b1, 12'h222, 1'b0, 1'b1);
        apply(1'b0, 1'b1, 1'b1, 12'h222, 1'b1, 1'b1);
        check("abort_busy", CW'(bus.busy), '0);
        idle(1'b1);
        check("abort_sb_c", bus.sb_c, 48'h111_111_111_111);
        check("abort_done", CW'(bus.done), '0);

        // protocol violations: commit in IDLE, start during LOAD, valid in ARM
        apply(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        check("err_commit_idle", CW'(bus.err), CW'(1));
        idle(1'b1);
        apply(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 1'b1, 12'h321, 1'b0, 1'b1);
        apply(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("err_start_load", CW'(bus.err), CW'(1));
        apply(1'b0, 1'b0, 1'b1, 12'h654, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 1'b1, 12'h987, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 1'b1, 12'hCBA, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 1'b1, 12'h0DE, 1'b0, 1'b1);
        check("err_valid_arm", CW'(bus.err), CW'(1));
        check("err_armed", CW'(bus.armed), CW'(1));
        apply(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        idle(1'b1);
        check("err_load_sb_c", bus.sb_c, 48'hCBA_987_654_321);

        // global enable gating, then asynchronous reset mid-load
        load_commit(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
        idle(1'b0);
        check("en0_sb_c", bus.sb_c, '0);
        idle(1'b1);
        check("en1_sb_c", bus.sb_c, 48'hFFF_FFF_FFF_FFF);
        apply(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 1'b1, 12'h0AA, 1'b0, 1'b1);
        hold = bus.sb_c;
        check("load_keeps_active", hold, 48'hFFF_FFF_FFF_FFF);
        rst = 1'b1;
        model_reset();
        #1;
        check("midrst_sb_c",  bus.sb_c, '0);
        check("midrst_busy",  CW'(bus.busy), '0);
        check("midrst_ready", CW'(bus.cfg_ready), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            apply($urandom_range(7) == 0, $urandom_range(15) == 0, $urandom_range(1) == 1,
                  W'($urandom), $urandom_range(3) == 0, $urandom_range(7) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
